// File: rtl/btn_debounce_sched.sv
// Four-button debouncer sharing one qualification counter.
// Each raw button is synchronized, then a small scheduler grants the shared
// counter to one button at a time (round-robin). A button's debounced level
// only changes after its synchronized level has differed from the debounced
// level for DEBOUNCE_CYCLES consecutive cycles. Presses (0->1) produce a
// single-cycle click pulse; releases update the level silently.
module btn_debounce_sched #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    output logic [3:0] click,
    output logic [3:0] stable,
    output logic       busy,
    output logic [1:0] grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Terminal count of the shared counter; the counter never goes past it.
    localparam logic [19:0] TERM = 20'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  sync_meta;
    logic [3:0]  s;
    logic [19:0] counter;
    logic [1:0]  rr_ptr;

    logic [3:0]  cand;
    logic        cand_any;
    logic [7:0]  cand2;
    logic [3:0]  rot;
    logic [1:0]  offset;
    logic [1:0]  cand_idx;
    logic        mismatch;

    // Two-flop synchronizer for the raw buttons (index 0..3 = U, D, L, R).
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep the two flops a true pipeline.
        if (rst) begin
            sync_meta <= '0;
            s         <= '0;
        end else begin
            sync_meta <= {btnR, btnL, btnD, btnU};
            s         <= sync_meta;
        end
    end

    // Round-robin pick: first index at or after rr_ptr whose level differs.
    always_comb begin
        cand     = s ^ stable;
        cand_any = |cand;
        cand2    = {cand, cand};
        rot      = cand2[rr_ptr +: 4];
        if (rot[0])      offset = 2'd0;
        else if (rot[1]) offset = 2'd1;
        else if (rot[2]) offset = 2'd2;
        else             offset = 2'd3;
        cand_idx = rr_ptr + offset;
        mismatch = s[grant] != stable[grant];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic for the counter scheduler.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (cand_any) state_next = COUNT;
            COUNT: begin
                if (!mismatch)           state_next = IDLE;
                else if (counter == TERM) state_next = COMMIT;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: grant, shared counter, round-robin pointer, levels and clicks.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= 2'b00;
            counter <= '0;
            rr_ptr  <= 2'b00;
            stable  <= 4'b0000;
            click   <= 4'b0000;
        end else begin
            click <= 4'b0000;
            case (state)
                IDLE: begin
                    if (cand_any) begin
                        grant   <= cand_idx;
                        counter <= '0;
                    end
                end
                COUNT: begin
                    if (!mismatch) begin
                        // Bounce: give the other buttons the next turn.
                        rr_ptr <= grant + 2'd1;
                    end else if (counter != TERM) begin
                        counter <= counter + 20'd1;
                    end
                end
                COMMIT: begin
                    stable[grant] <= ~stable[grant];
                    click[grant]  <= ~stable[grant];
                    rr_ptr        <= grant + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
